// File: rtl/ark_pkg.sv
// Shared types for the ark accumulator core: opcode map and control FSM states.
package ark_pkg;

  typedef enum logic [3:0] {
    OpNop,
    OpAdd,
    OpSub,
    OpAnd,
    OpOr,
    OpXor,
    OpShl,
    OpShr,
    OpMov,
    OpLsi,
    OpLd,
    OpSt,
    OpBr,
    OpBro,
    OpClo,
    OpHalt
  } opcode_e;

  typedef enum logic [1:0] {
    StFetch,
    StExec,
    StMem,
    StHalted
  } state_e;

  localparam logic [15:0] InstCountMax = 16'hFFFF;

endpackage

// File: rtl/ark_if.sv
// Instruction ROM and data memory bus between the ark core and its memories.
interface ark_if #(
  parameter int unsigned DW  = 8,
  parameter int unsigned PCW = 8,
  parameter int unsigned IW  = 10
);

  logic [PCW-1:0] imem_addr;
  logic [IW-1:0]  imem_data;
  logic           dmem_req;
  logic           dmem_we;
  logic [DW-1:0]  dmem_addr;
  logic [DW-1:0]  dmem_wdata;
  logic [DW-1:0]  dmem_rdata;
  logic           dmem_ack;

  modport master (
    output imem_addr,
    input  imem_data,
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_ack
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_ack
  );

endinterface

// File: rtl/ark_decode.sv
// Pure field extraction from the instruction register; no state.
module ark_decode
  import ark_pkg::*;
#(
  parameter int unsigned RSW = 3,
  parameter int unsigned IW  = 4 + 2 * RSW
) (
  input  logic [IW-1:0]    ir,
  output opcode_e          op,
  output logic [RSW-1:0]   rd,
  output logic [RSW-1:0]   rs,
  output logic [2*RSW-1:0] imm,
  output logic [3:0]       imm4
);

  assign op   = opcode_e'(ir[IW-1 -: 4]);
  assign rd   = ir[2*RSW-1 -: RSW];
  assign rs   = ir[RSW-1:0];
  assign imm  = ir[2*RSW-1:0];
  assign imm4 = ir[3:0];

endmodule

// File: rtl/ark_core.sv
// Multi-cycle accumulator core: FETCH/EXEC/MEM/HALTED control, inline register file and ALU.
module ark_core
  import ark_pkg::*;
#(
  parameter int unsigned DW   = 8,
  parameter int unsigned PCW  = 8,
  parameter int unsigned NREG = 8
) (
  input  logic        CLK,
  input  logic        start,
  ark_if.master       bus,
  output logic        halt,
  output logic [15:0] inst_count,
  output logic        ovf
);

  localparam int unsigned RSW  = $clog2(NREG);
  localparam int unsigned IW   = 4 + 2 * RSW;
  localparam int unsigned IMMW = 2 * RSW;

  state_e         state_q, state_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [IW-1:0]  ir_q, ir_d;
  logic           ovf_q, ovf_d;
  logic [15:0]    cnt_q;
  logic [DW-1:0]  regs_q [NREG];

  logic           retire;
  logic           rf_we;
  logic [RSW-1:0] rf_waddr;
  logic [DW-1:0]  rf_wdata;

  opcode_e         op;
  logic [RSW-1:0]  rd;
  logic [RSW-1:0]  rs;
  logic [IMMW-1:0] imm;
  logic [3:0]      imm4;

  ark_decode #(
    .RSW (RSW),
    .IW  (IW)
  ) u_decode (
    .ir   (ir_q),
    .op   (op),
    .rd   (rd),
    .rs   (rs),
    .imm  (imm),
    .imm4 (imm4)
  );

  logic [DW-1:0]  r0_val, rd_val, rs_val;
  logic [DW:0]    add_res, sub_res;
  logic [PCW-1:0] pc_inc, pc_br;

  assign r0_val  = regs_q[0];
  assign rd_val  = regs_q[rd];
  assign rs_val  = regs_q[rs];
  // Extra top bit carries the ADD carry-out / SUB borrow.
  assign add_res = {1'b0, rd_val} + {1'b0, rs_val};
  assign sub_res = {1'b0, rd_val} - {1'b0, rs_val};
  assign pc_inc  = pc_q + PCW'(1);
  assign pc_br   = pc_q + PCW'($signed(imm));

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    ovf_d    = ovf_q;
    retire   = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = rd;
    rf_wdata = '0;
    unique case (state_q)
      StFetch: begin
        ir_d    = bus.imem_data;
        state_d = StExec;
      end
      StExec: begin
        state_d = StFetch;
        pc_d    = pc_inc;
        retire  = 1'b1;
        case (op)
          OpAdd: begin
            rf_we    = 1'b1;
            rf_wdata = add_res[DW-1:0];
            ovf_d    = add_res[DW];
          end
          OpSub: begin
            rf_we    = 1'b1;
            rf_wdata = sub_res[DW-1:0];
            ovf_d    = sub_res[DW];
          end
          OpAnd: begin
            rf_we    = 1'b1;
            rf_wdata = rd_val & rs_val;
            ovf_d    = 1'b0;
          end
          OpOr: begin
            rf_we    = 1'b1;
            rf_wdata = rd_val | rs_val;
            ovf_d    = 1'b0;
          end
          OpXor: begin
            rf_we    = 1'b1;
            rf_wdata = rd_val ^ rs_val;
            ovf_d    = 1'b0;
          end
          OpShl: begin
            rf_we    = 1'b1;
            rf_wdata = {rd_val[DW-2:0], 1'b0};
            ovf_d    = rd_val[DW-1];
          end
          OpShr: begin
            rf_we    = 1'b1;
            rf_wdata = {1'b0, rd_val[DW-1:1]};
            ovf_d    = rd_val[0];
          end
          OpMov: begin
            rf_we    = 1'b1;
            rf_wdata = rs_val;
          end
          OpLsi: begin
            rf_we    = 1'b1;
            rf_waddr = '0;
            rf_wdata = {r0_val[DW-5:0], imm4};
          end
          OpLd, OpSt: begin
            state_d = StMem;
            pc_d    = pc_q;
            retire  = 1'b0;
          end
          OpBr:  pc_d = pc_br;
          OpBro: pc_d = ovf_q ? pc_inc : pc_br;
          OpClo: ovf_d = 1'b0;
          OpHalt: begin
            state_d = StHalted;
            pc_d    = pc_q;
            retire  = 1'b0;
          end
          default: ;
        endcase
      end
      StMem: begin
        if (bus.dmem_ack) begin
          state_d  = StFetch;
          pc_d     = pc_inc;
          retire   = 1'b1;
          rf_we    = (op == OpLd);
          rf_wdata = bus.dmem_rdata;
        end
      end
      StHalted: ;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (start) begin
      state_q <= StFetch;
      pc_q    <= '0;
      ir_q    <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ovf_q   <= ovf_d;
      if (retire && (cnt_q != InstCountMax)) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (start) begin
      regs_q <= '{default: '0};
    end else if (rf_we) begin
      regs_q[rf_waddr] <= rf_wdata;
    end
  end

  assign bus.imem_addr  = pc_q;
  assign bus.dmem_req   = (state_q == StMem);
  assign bus.dmem_we    = (state_q == StMem) && (op == OpSt);
  assign bus.dmem_addr  = r0_val;
  assign bus.dmem_wdata = rs_val;
  assign halt           = (state_q == StHalted);
  assign inst_count     = cnt_q;
  assign ovf            = ovf_q;

endmodule

// File: doc/ark_core.md
ARK_CORE -- requirements
Module: ark_core

Interface
REQ-001 Parameter DW, 8, data/register width; SHALL be >= 8.
REQ-002 Parameter PCW, 8, program counter width.
REQ-003 Parameter NREG, 8, register count (power of 2); RSW = log2(NREG); instruction width IW = 4 + 2*RSW.
REQ-004 CLK  input  1  sole clock, all state on rising edge.
REQ-005 start  input  1  reset, synchronous and active-high.
REQ-006 imem_addr  output  PCW  instruction address, equal to PC.
REQ-007 imem_data  input  IW  instruction word, valid same cycle as imem_addr (combinational ROM).
REQ-008 dmem_req  output  1  data memory request.
REQ-009 dmem_we  output  1  1 = store, 0 = load; meaningful only with dmem_req.
REQ-010 dmem_addr  output  DW  data address, always R0 (accumulator).
REQ-011 dmem_wdata  output  DW  store data.
REQ-012 dmem_rdata  input  DW  load data, valid with dmem_ack.
REQ-013 dmem_ack  input  1  one-cycle completion pulse from data memory.
REQ-014 halt  output  1  core stopped.
REQ-015 inst_count  output  16  retired-instruction counter.
REQ-016 ovf  output  1  registered overflow flag.

Function
REQ-017 Encoding SHALL be opcode = IR[IW-1:IW-4], rd = next RSW bits, rs = low RSW bits, imm = low 2*RSW bits; imm4 = IR[3:0].
REQ-018 FSM SHALL have states FETCH, EXEC, MEM, HALTED; FETCH latches imem_data into IR and goes to EXEC in one cycle.
REQ-019 EXEC for NOP/ADD/SUB/AND/OR/XOR/SHL/SHR/MOV/LSI/CLO SHALL write result in that cycle, PC <= PC+1, go FETCH (2 cycles per instruction).
REQ-020 ADD/SUB: rd <= rd op rs modulo 2^DW; ovf <= carry-out (ADD) or borrow (SUB).
REQ-021 AND/OR/XOR: rd <= rd op rs; ovf <= 0. SHL/SHR: rd shifted by 1, zero fill; ovf <= shifted-out bit. MOV: rd <= rs, ovf unchanged. CLO: ovf <= 0.
REQ-022 LSI: R0 <= {R0[DW-5:0], imm4}; other registers and ovf unchanged.
REQ-023 BR: PC <= PC + sign-extended imm, modulo 2^PCW. BRO: same if ovf==0, else PC+1. Both go FETCH.
REQ-024 LD/ST SHALL go to MEM; MEM asserts dmem_req with dmem_addr = R0, dmem_we = (ST), dmem_wdata = R[rs], all held stable until dmem_ack.
REQ-025 On dmem_ack in MEM: LD writes dmem_rdata to R[rd]; PC <= PC+1; dmem_req deasserted next cycle; go FETCH. No cycle limit on wait.
REQ-026 dmem_ack outside MEM SHALL be ignored.
REQ-027 HALT in EXEC SHALL enter HALTED; halt = 1 from next cycle; PC, registers, ovf, inst_count frozen until start.
REQ-028 inst_count SHALL increment by 1 per retired non-HALT instruction and saturate at 16'hFFFF.
REQ-029 Writes to R0 by any instruction SHALL update dmem_addr from the next cycle.

Reset
REQ-030 While start = 1: state FETCH, PC = 0, IR = 0, all registers 0, ovf = 0, inst_count = 0, halt = 0, dmem_req = 0, dmem_we = 0.
REQ-031 start during MEM SHALL abandon the access: dmem_req = 0 the cycle after start is sampled; late dmem_ack ignored.
REQ-032 start in HALTED SHALL restart execution from PC = 0.

Structure
REQ-033 Package ark_pkg SHALL hold opcode enum (NOP, ADD, SUB, AND, OR, XOR, SHL, SHR, MOV, LSI, LD, ST, BR, BRO, CLO, HALT = 0..15) and FSM state enum.
REQ-034 Combinational decoder SHALL be sub-module ark_decode (IR -> opcode class, rd, rs, imm); register file and ALU inline.

Verification
REQ-035 Reset, LSI 0xA, LSI 0x5 -> R0 = 0xA5, inst_count = 2 at cycle 4, ovf = 0.
REQ-036 R1 = 0xF0, R2 = 0x20, ADD R1,R2, BRO +3 -> R1 = 0x10, ovf = 1, branch not taken, PC advances by 1.
REQ-037 R0 = 0x40, LD R3 with dmem_ack 3 cycles after req -> dmem_req high 4 cycles, addr 0x40 stable, R3 = dmem_rdata, PC+1.
REQ-038 start asserted in 2nd MEM wait cycle, ack 2 cycles later -> dmem_req low next cycle, no register write, PC = 0.
REQ-039 BR -1 at PC 0 -> PC = 2^PCW-1 (wrap); HALT there -> halt = 1, inst_count frozen across 10 cycles.
